paddle_axis: RTL and testbench

- Second-generation player paddle for the VGA pong datapath.
- Turns two active-low push-buttons into a vertical paddle position.
- Moves with auto-repeat and hold-to-accelerate, and clamps to the playfield.
- Renders the paddle for the current raster x,y and reports paddle hits to the ball logic. One instance per player.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/sw_sync.sv | 27 ++
 rtl/paddle_axis.sv | 184 ++++++++++++++++++
 tb/tb_paddle_axis.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the VGA pong datapath.
package pong_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    AUTO = 2'd3
  } paddle_state_t;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchroniser for an asynchronous push-button; resets to RST_VAL.
module sw_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/paddle_axis.sv
// Player paddle: button-driven vertical position with auto-repeat and acceleration, plus rendering.
// Define PADDLE_AUTO_EN to add the auto_en/ball_y ports and the ball-tracking AUTO state.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int unsigned XPOS       = 50,
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned HEIGHT     = 100,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned RESET_Y    = 190,
  parameter int unsigned HOLD       = 50000,
  parameter int unsigned MIN_HOLD   = 12500,
  parameter int unsigned ACCEL_STEP = 5000,
  parameter logic [2:0]  COLOR      = COL_CYAN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       swup,
  input  logic       swdn,
`ifdef PADDLE_AUTO_EN
  input  logic       auto_en,
  input  logic [9:0] ball_y,
`endif
  output logic [2:0] color,
  output logic       onpaddle,
  output logic [9:0] ypos,
  output logic       moving,
  output logic       at_limit
);

  localparam int unsigned    CW     = $clog2(HOLD + 1);
  localparam logic [9:0]     MAX_Y  = 10'(SCREEN_H - HEIGHT);
  localparam logic [9:0]     RST_Y  = 10'(RESET_Y);
  localparam logic [CW-1:0]  HOLD_C = CW'(HOLD);
  localparam logic [CW-1:0]  MIN_C  = CW'(MIN_HOLD);
  localparam logic [10:0]    X_LO   = 11'(XPOS);
  localparam logic [10:0]    X_HI   = 11'(XPOS + WIDTH);
  localparam logic [10:0]    H_C    = 11'(HEIGHT);

  paddle_state_t r_state;
  logic [9:0]    r_ypos;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_interval;

  logic          w_up_s;
  logic          w_dn_s;
  logic          w_at_top;
  logic          w_at_bot;
  logic          w_cnt_done;
  logic [31:0]   w_iv32;
  logic [CW-1:0] w_next_iv;
  logic          w_atx;
  logic          w_aty;

  sw_sync #(.RST_VAL(1'b1)) u_sync_up (
    .clk   (clk),
    .rst_n (rst),
    .i_d   (swup),
    .o_q   (w_up_s)
  );

  sw_sync #(.RST_VAL(1'b1)) u_sync_dn (
    .clk   (clk),
    .rst_n (rst),
    .i_d   (swdn),
    .o_q   (w_dn_s)
  );

  assign w_at_top   = (r_ypos == 10'd0);
  assign w_at_bot   = (r_ypos == MAX_Y);
  assign w_cnt_done = (r_cnt == r_interval - CW'(1));

  // Acceleration saturates at MIN_HOLD instead of underflowing the interval.
  assign w_iv32    = 32'(r_interval);
  assign w_next_iv = (w_iv32 >= MIN_HOLD + ACCEL_STEP) ? CW'(w_iv32 - ACCEL_STEP) : MIN_C;

`ifdef PADDLE_AUTO_EN
  logic [10:0] w_off;
  logic [9:0]  w_target;

  assign w_off = {1'b0, ball_y} - 11'(HEIGHT / 2);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_target = 10'd0;
    if ({1'b0, ball_y} >= 11'(HEIGHT / 2)) begin
      if (w_off > {1'b0, MAX_Y}) w_target = MAX_Y;
      else                       w_target = w_off[9:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ypos     <= RST_Y;
      r_cnt      <= '0;
      r_interval <= HOLD_C;
    end else begin
`ifdef PADDLE_AUTO_EN
      if (auto_en && r_state != AUTO) begin
        r_state <= AUTO;
        r_cnt   <= '0;
      end else
`endif
      case (r_state)
        IDLE: begin
          if (!w_up_s && w_dn_s) begin
            r_state    <= UP;
            r_cnt      <= '0;
            r_interval <= HOLD_C;
            if (!w_at_top) r_ypos <= r_ypos - 10'd1;
          end else if (!w_dn_s && w_up_s) begin
            r_state    <= DOWN;
            r_cnt      <= '0;
            r_interval <= HOLD_C;
            if (!w_at_bot) r_ypos <= r_ypos + 10'd1;
          end
        end
        UP: begin
          if (w_up_s || !w_dn_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_done) begin
            r_cnt      <= '0;
            r_interval <= w_next_iv;
            if (!w_at_top) r_ypos <= r_ypos - 10'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DOWN: begin
          if (w_dn_s || !w_up_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_done) begin
            r_cnt      <= '0;
            r_interval <= w_next_iv;
            if (!w_at_bot) r_ypos <= r_ypos + 10'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef PADDLE_AUTO_EN
        AUTO: begin
          if (!auto_en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == MIN_C - CW'(1)) begin
            r_cnt <= '0;
            if (r_ypos < w_target)      r_ypos <= r_ypos + 10'd1;
            else if (r_ypos > w_target) r_ypos <= r_ypos - 10'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Rendering widens to 11 bits so ypos+HEIGHT near the bottom cannot wrap.
  assign w_atx = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI);
  assign w_aty = ({1'b0, y} >= {1'b0, r_ypos}) && ({1'b0, y} < {1'b0, r_ypos} + H_C);

  assign onpaddle = w_atx & w_aty;
  assign color    = onpaddle ? COLOR : COL_BLACK;
  assign ypos     = r_ypos;
  assign at_limit = w_at_top | w_at_bot;

`ifdef PADDLE_AUTO_EN
  assign moving = (r_state == UP) || (r_state == DOWN) ||
                  ((r_state == AUTO) && (r_ypos != w_target));
`else
  assign moving = (r_state == UP) || (r_state == DOWN);
`endif

endmodule

// File: tb/tb_paddle_axis.sv
// Directed self-checking bench for paddle_axis; the AUTO section runs only when PADDLE_AUTO_EN is defined.
module tb_paddle_axis;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] x   = 10'd55;
  logic [9:0] y   = 10'd200;
  logic       swup   = 1'b1;
  logic       swdn   = 1'b1;
  logic       swup_c = 1'b1;
  logic       swdn_c = 1'b1;

  logic [2:0] color,    color_c;
  logic       onpaddle, onpaddle_c;
  logic [9:0] ypos,     ypos_c;
  logic       moving,   moving_c;
  logic       at_limit, at_limit_c;

`ifdef PADDLE_AUTO_EN
  logic       auto_en = 1'b0;
  logic [9:0] ball_y  = 10'd0;
  logic       auto_en_c = 1'b0;
  logic [9:0] ball_y_c  = 10'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  paddle_axis #(
    .HOLD       (8),
    .MIN_HOLD   (2),
    .ACCEL_STEP (2)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .swup     (swup),
    .swdn     (swdn),
`ifdef PADDLE_AUTO_EN
    .auto_en  (auto_en),
    .ball_y   (ball_y),
`endif
    .color    (color),
    .onpaddle (onpaddle),
    .ypos     (ypos),
    .moving   (moving),
    .at_limit (at_limit)
  );

  paddle_axis #(
    .RESET_Y    (1),
    .HOLD       (8),
    .MIN_HOLD   (2),
    .ACCEL_STEP (2)
  ) u_clamp (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .swup     (swup_c),
    .swdn     (swdn_c),
`ifdef PADDLE_AUTO_EN
    .auto_en  (auto_en_c),
    .ball_y   (ball_y_c),
`endif
    .color    (color_c),
    .onpaddle (onpaddle_c),
    .ypos     (ypos_c),
    .moving   (moving_c),
    .at_limit (at_limit_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int probe_x[8]  = '{55, 70, 49, 50, 69, 55, 55, 55};
  int probe_y[8]  = '{200, 200, 200, 200, 200, 189, 289, 290};
  int probe_on[8] = '{1, 0, 0, 1, 1, 0, 1, 0};
  int steps[9]    = '{3, 11, 17, 21, 23, 25, 27, 29, 31};

  initial begin
    int exp_y;
    int si;

    tick(2);
    check("rst_ypos", ypos, 190);
    check("rst_moving", moving, 0);
    check("rst_at_limit", at_limit, 0);
    check("rst_clamp_ypos", ypos_c, 1);
    check("rst_clamp_at_limit", at_limit_c, 0);

    for (int i = 0; i < 8; i++) begin
      x = 10'(probe_x[i]);
      y = 10'(probe_y[i]);
      #1;
      check("probe_onpaddle", onpaddle, probe_on[i]);
      check("probe_color", color, (probe_on[i] != 0) ? 3'b011 : 3'b000);
    end

    rst = 1'b1;
    tick(3);

    // Single tap: one step 3 cycles after the press, then back to idle.
    swup = 1'b0;
    tick(1); check("tap_e1", ypos, 190);
    tick(1); check("tap_e2", ypos, 190);
    tick(1); check("tap_e3", ypos, 189);
    check("tap_moving", moving, 1);
    tick(1);
    swup = 1'b1;
    tick(10);
    check("tap_final", ypos, 189);
    check("tap_idle", moving, 0);

    // Hold down with acceleration; release lands after edge 30.
    exp_y = 189;
    si    = 0;
    swdn  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (si < 9 && steps[si] == k) begin
        exp_y++;
        si++;
      end
      check("hold_ypos", ypos, exp_y);
      if (k == 30) swdn = 1'b1;
    end
    check("hold_final", ypos, 198);
    check("hold_idle", moving, 0);

    // Both buttons pressed: no motion.
    swup = 1'b0;
    swdn = 1'b0;
    tick(10);
    check("both_ypos", ypos, 198);
    check("both_moving", moving, 0);
    swup = 1'b1;
    swdn = 1'b1;
    tick(4);

    // Reset mid-move aborts immediately; motion needs a fresh press.
    swdn = 1'b0;
    tick(6);
    check("pre_rst_ypos", ypos, 199);
    check("pre_rst_moving", moving, 1);
    rst = 1'b0;
    #1;
    check("async_rst_ypos", ypos, 190);
    check("async_rst_moving", moving, 0);
    swdn = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(10);
    check("post_rst_ypos", ypos, 190);
    check("post_rst_moving", moving, 0);
    swdn = 1'b0;
    tick(2); check("fresh_e2", ypos, 190);
    tick(1); check("fresh_e3", ypos, 191);
    swdn = 1'b1;
    tick(8);
    check("fresh_idle", moving, 0);

`ifdef PADDLE_AUTO_EN
    // Track ball_y=300 -> target 250, one pixel per 2 cycles.
    auto_en = 1'b1;
    ball_y  = 10'd300;
    tick(1);
    tick(2);
    check("auto_first_step", ypos, 192);
    check("auto_moving", moving, 1);
    tick(130);
    check("auto_target", ypos, 250);
    check("auto_settled", moving, 0);
    auto_en = 1'b0;
    tick(3);
    check("auto_exit_ypos", ypos, 250);
    check("auto_exit_moving", moving, 0);
`endif

    // Clamp at the top: step 1->0, then hold at 0 while still moving.
    swup_c = 1'b0;
    tick(2); check("clamp_e2", ypos_c, 1);
    tick(1); check("clamp_e3", ypos_c, 0);
    check("clamp_limit_e3", at_limit_c, 1);
    tick(100);
    check("clamp_hold_ypos", ypos_c, 0);
    check("clamp_hold_limit", at_limit_c, 1);
    check("clamp_hold_moving", moving_c, 1);
    swup_c = 1'b1;
    tick(6);
    check("clamp_idle", moving_c, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
